mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates one word-wide RAM port between an instruction-fetch requester
// and a data read/write requester.
//
// On a grant, the block latches the request's address, store data and
// read/write type. The RAM port is driven only from those latched values.
// The block then waits for the RAM to report ACCESS and pulses the matching
// hit in that same cycle. A wait that reaches TIMEOUT cycles, or a RAM ERROR
// status, ends the transaction with a one-cycle err pulse instead of a hit.
//
// Data normally wins arbitration. The starve counter limits how long a
// pending instruction fetch can be held off by data grants.
//
// Parameters
//   TIMEOUT   wait cycles allowed per RAM transaction before err
//   STARVE    consecutive data grants allowed while iREN is pending
//
// Ports
//   CLK, RST           clock; asynchronous active-high reset
//   iREN, iaddr        instruction fetch request and address
//   dREN, dWEN         data read / write request (write wins if both high)
//   daddr, dstore      data address and write value
//   ihit, iload        fetch done pulse; fetched word (held until next ihit)
//   dhit, dload        data done pulse; read word (held until next read dhit)
//   err                transaction aborted (timeout or RAM ERROR)
//   ramREN, ramWEN     RAM enables (never both high)
//   ramaddr, ramstore  RAM address and write data
//   ramload, ramstate  RAM read data and status (FREE/BUSY/ACCESS/ERROR)
module mem_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int STARVE  = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        err,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam int CW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
    localparam int SW = ($clog2(STARVE + 1) > 1) ? $clog2(STARVE + 1) : 1;

    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [SW-1:0] STARVE_C  = SW'(STARVE);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t        state_reg,  state_next;
    logic [CW-1:0] wait_reg,   wait_next;
    logic [SW-1:0] starve_reg, starve_next;
    logic [31:0]   addr_reg,   addr_next;
    logic [31:0]   store_reg,  store_next;
    logic          wr_reg,     wr_next;
    logic [31:0]   iload_reg,  iload_next;
    logic [31:0]   dload_reg,  dload_next;

    logic          dreq;
    logic          starved;
    logic [CW-1:0] wait_inc;

    assign dreq     = dREN | dWEN;
    assign starved  = (starve_reg == STARVE_C);
    assign wait_inc = wait_reg + 1'b1;

    // All state is cleared asynchronously. The RAM enables and the hit/err
    // pulses are decoded from state_reg, so they drop while RST is high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg  <= IDLE;
            wait_reg   <= '0;
            starve_reg <= '0;
            addr_reg   <= '0;
            store_reg  <= '0;
            wr_reg     <= 1'b0;
            iload_reg  <= '0;
            dload_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            wait_reg   <= wait_next;
            starve_reg <= starve_next;
            addr_reg   <= addr_next;
            store_reg  <= store_next;
            wr_reg     <= wr_next;
            iload_reg  <= iload_next;
            dload_reg  <= dload_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        wait_next   = wait_reg;
        starve_next = starve_reg;
        addr_next   = addr_reg;
        store_next  = store_reg;
        wr_next     = wr_reg;
        iload_next  = iload_reg;
        dload_next  = dload_reg;
        ihit        = 1'b0;
        dhit        = 1'b0;
        err         = 1'b0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;

        case (state_reg)
            IDLE: begin
                // A pending fetch only beats data once it has been passed
                // over STARVE times in a row.
                if (dreq && !(iREN && starved)) begin
                    state_next = DATA;
                    addr_next  = daddr;
                    store_next = dstore;
                    wr_next    = dWEN;
                    wait_next  = '0;
                    // Only grants that make a pending fetch wait are counted.
                    // Since starved is false here, the counter saturates at STARVE.
                    if (iREN) begin
                        starve_next = starve_reg + 1'b1;
                    end
                end else if (iREN) begin
                    state_next  = INSTR;
                    addr_next   = iaddr;
                    store_next  = dstore;
                    wr_next     = 1'b0;
                    wait_next   = '0;
                    starve_next = '0;
                end
            end

            DATA: begin
                ramREN = ~wr_reg;
                ramWEN = wr_reg;
                // Withdrawal takes precedence: a requester that has dropped
                // its enable gets neither a hit nor an err.
                if (!dreq) begin
                    state_next = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    dhit       = 1'b1;
                    state_next = IDLE;
                    if (!wr_reg) begin
                        dload_next = ramload;
                    end
                end else if (ramstate == RAM_ERROR) begin
                    state_next = FAULT;
                end else begin
                    wait_next = wait_inc;
                    if (wait_inc >= TIMEOUT_C) begin
                        state_next = FAULT;
                    end
                end
            end

            INSTR: begin
                ramREN = 1'b1;
                if (!iREN) begin
                    state_next = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    ihit       = 1'b1;
                    iload_next = ramload;
                    state_next = IDLE;
                end else if (ramstate == RAM_ERROR) begin
                    state_next = FAULT;
                end else begin
                    wait_next = wait_inc;
                    if (wait_inc >= TIMEOUT_C) begin
                        state_next = FAULT;
                    end
                end
            end

            FAULT: begin
                err        = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The hit is combinational in the ACCESS cycle, but the capture register
    // loads only at the end of that cycle. Bypassing ramload during the hit
    // makes the word valid together with the pulse.
    assign iload    = ihit ? ramload : iload_reg;
    assign dload    = (dhit && !wr_reg) ? ramload : dload_reg;
    assign ramaddr  = addr_reg;
    assign ramstore = store_reg;

endmodule
